// File: rtl/tmr_pkg.sv
// Shared constants and the bitwise 2-of-3 majority helper for the TMR voter.
package tmr_pkg;

  localparam int unsigned TMR_WIDTH_DEF     = 4;
  localparam int unsigned TMR_CNT_WIDTH_DEF = 8;
  // Widest replica the majority helper accepts; callers zero-extend and truncate.
  localparam int unsigned TMR_MAX_WIDTH     = 64;

  function automatic logic [TMR_MAX_WIDTH-1:0] tmr_maj(input logic [TMR_MAX_WIDTH-1:0] a,
                                                       input logic [TMR_MAX_WIDTH-1:0] b,
                                                       input logic [TMR_MAX_WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tmr_vote_if.sv
// Replica inputs, clear and health-monitor outputs of the TMR voter.
interface tmr_vote_if
  import tmr_pkg::*;
#(
  parameter int unsigned Width    = TMR_WIDTH_DEF,
  parameter int unsigned CntWidth = TMR_CNT_WIDTH_DEF
);

  logic                CLR;
  logic [Width-1:0]    A;
  logic [Width-1:0]    B;
  logic [Width-1:0]    C;
  logic [Width-1:0]    V;
  logic                MIS;
  logic                FLT_A;
  logic                FLT_B;
  logic                FLT_C;
  logic [CntWidth-1:0] ERR_CNT;

  modport master (
    output CLR, A, B, C,
    input  V, MIS, FLT_A, FLT_B, FLT_C, ERR_CNT
  );

  modport slave (
    input  CLR, A, B, C,
    output V, MIS, FLT_A, FLT_B, FLT_C, ERR_CNT
  );

endinterface

// File: rtl/tmr_vote_core.sv
// Combinational vote, replica mismatch and per-lane disagreement with the vote.
module tmr_vote_core
  import tmr_pkg::*;
#(
  parameter int unsigned Width = TMR_WIDTH_DEF
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic [Width-1:0] c,
  output logic [Width-1:0] vote_c,
  output logic             mis_c,
  output logic             d_a,
  output logic             d_b,
  output logic             d_c
);

  assign vote_c = Width'(tmr_maj(TMR_MAX_WIDTH'(a), TMR_MAX_WIDTH'(b), TMR_MAX_WIDTH'(c)));
  assign mis_c  = (a != b) | (b != c);
  assign d_a    = (a != vote_c);
  assign d_b    = (b != vote_c);
  assign d_c    = (c != vote_c);

endmodule

// File: rtl/tmr_vote.sv
// TMR majority voter with registered mismatch, sticky lane faults and saturating counter.
// Define TMR_VOTE_REG_OUT_EN to register V (one cycle latency, reset to 0).
module tmr_vote
  import tmr_pkg::*;
#(
  parameter int unsigned Width    = TMR_WIDTH_DEF,
  parameter int unsigned CntWidth = TMR_CNT_WIDTH_DEF
) (
  input logic       CLK,
  input logic       RST,
  tmr_vote_if.slave bus
);

  logic [Width-1:0]    vote_c;
  logic                mis_c;
  logic                d_a;
  logic                d_b;
  logic                d_c;

  logic                mis_q;
  logic                flt_a_q;
  logic                flt_b_q;
  logic                flt_c_q;
  logic [CntWidth-1:0] err_cnt_q;

  tmr_vote_core #(
    .Width (Width)
  ) u_core (
    .a      (bus.A),
    .b      (bus.B),
    .c      (bus.C),
    .vote_c (vote_c),
    .mis_c  (mis_c),
    .d_a    (d_a),
    .d_b    (d_b),
    .d_c    (d_c)
  );

  // CLR beats a simultaneous mismatch; MIS keeps tracking the replicas regardless.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mis_q     <= 1'b0;
      flt_a_q   <= 1'b0;
      flt_b_q   <= 1'b0;
      flt_c_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      mis_q <= mis_c;
      if (bus.CLR) begin
        flt_a_q   <= 1'b0;
        flt_b_q   <= 1'b0;
        flt_c_q   <= 1'b0;
        err_cnt_q <= '0;
      end else begin
        flt_a_q <= flt_a_q | d_a;
        flt_b_q <= flt_b_q | d_b;
        flt_c_q <= flt_c_q | d_c;
        if (mis_c && (err_cnt_q != '1)) begin
          err_cnt_q <= err_cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef TMR_VOTE_REG_OUT_EN
  logic [Width-1:0] v_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v_q <= '0;
    end else begin
      v_q <= vote_c;
    end
  end

  assign bus.V = v_q;
`else
  assign bus.V = vote_c;
`endif

  assign bus.MIS     = mis_q;
  assign bus.FLT_A   = flt_a_q;
  assign bus.FLT_B   = flt_b_q;
  assign bus.FLT_C   = flt_c_q;
  assign bus.ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_tmr_vote.sv
// Scoreboard bench for tmr_vote (default build): stimulus queues expectations, a
// mid-cycle monitor pops and compares those due in the current cycle.
module tb_tmr_vote;

  localparam int unsigned Width    = 4;
  localparam int unsigned CntWidth = 8;

  localparam int SelV   = 0;
  localparam int SelMis = 1;
  localparam int SelFa  = 2;
  localparam int SelFb  = 3;
  localparam int SelFc  = 4;
  localparam int SelErr = 5;

  typedef struct {
    string      name;
    int         at;
    int         sel;
    logic [7:0] val;
  } exp_t;

  logic CLK;
  logic RST;
  int   cyc;
  int   n_checks;
  int   n_pass;
  exp_t sb_q[$];

  tmr_vote_if #(.Width(Width), .CntWidth(CntWidth)) bus ();

  tmr_vote #(
    .Width    (Width),
    .CntWidth (CntWidth)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic expect_at(input string name, input int at, input int sel, input logic [7:0] val);
    exp_t e;
    e.name = name;
    e.at   = at;
    e.sel  = sel;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    bus.A = a;
    bus.B = b;
    bus.C = c;
  endtask

  task automatic expect_all(input string name, input logic mis, input logic fa, input logic fb,
                            input logic fc, input logic [7:0] err);
    expect_at({name, "_mis"}, cyc, SelMis, {7'd0, mis});
    expect_at({name, "_flt_a"}, cyc, SelFa, {7'd0, fa});
    expect_at({name, "_flt_b"}, cyc, SelFb, {7'd0, fb});
    expect_at({name, "_flt_c"}, cyc, SelFc, {7'd0, fc});
    expect_at({name, "_err_cnt"}, cyc, SelErr, err);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from register updates.
  always @(negedge CLK) begin
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      exp_t       e;
      logic [7:0] act;
      e = sb_q.pop_front();
      case (e.sel)
        SelV:    act = {4'd0, bus.V};
        SelMis:  act = {7'd0, bus.MIS};
        SelFa:   act = {7'd0, bus.FLT_A};
        SelFb:   act = {7'd0, bus.FLT_B};
        SelFc:   act = {7'd0, bus.FLT_C};
        default: act = bus.ERR_CNT;
      endcase
      n_checks++;
      if (act === e.val) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", e.name, act, e.val, cyc);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    RST      = 1'b1;
    bus.CLR  = 1'b0;
    drive(4'h5, 4'h5, 4'h5);

    // Reset state, V follows the inputs throughout.
    step();
    n_checks++;
    if (bus.V === 4'h5) n_pass++;
    else $display("FAIL direct_rst_v: got 0x%0h, expected 0x5", bus.V);
    n_checks++;
    if (bus.MIS === 1'b0) n_pass++;
    else $display("FAIL direct_rst_mis: got %0b, expected 0", bus.MIS);
    expect_at("rst_v", cyc, SelV, 8'h05);
    expect_all("rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    RST = 1'b0;
    expect_all("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Single-lane fault on A.
    step();
    drive(4'h3, 4'hA, 4'hA);
    expect_at("single_v", cyc, SelV, 8'h0A);
    step();
    drive(4'hA, 4'hA, 4'hA);
    expect_at("single_v_back", cyc, SelV, 8'h0A);
    expect_all("single", 1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
    step();
    expect_all("single_sticky", 1'b0, 1'b1, 1'b0, 1'b0, 8'h01);

    // Each replica corrupted in a different bit.
    drive(4'hE, 4'hD, 4'hB);
    expect_at("dist_v", cyc, SelV, 8'h0F);
    step();
    drive(4'h0, 4'h0, 4'h0);
    expect_all("dist", 1'b1, 1'b1, 1'b1, 1'b1, 8'h02);
    step();
    expect_all("dist_quiet", 1'b0, 1'b1, 1'b1, 1'b1, 8'h02);

    // CLR together with a mismatch.
    drive(4'h1, 4'h0, 4'h0);
    bus.CLR = 1'b1;
    step();
    n_checks++;
    if (bus.MIS === 1'b1) n_pass++;
    else $display("FAIL direct_clr_mis: got %0b, expected 1", bus.MIS);
    n_checks++;
    if (bus.ERR_CNT === 8'h00) n_pass++;
    else $display("FAIL direct_clr_err: got 0x%0h, expected 0x00", bus.ERR_CNT);
    bus.CLR = 1'b0;
    drive(4'h0, 4'h0, 4'h0);
    expect_all("clr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    expect_all("clr_after", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Saturation under a held mismatch.
    drive(4'h1, 4'h0, 4'h0);
    expect_at("sat_v", cyc, SelV, 8'h00);
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 1)   expect_at("sat_cnt_1", cyc, SelErr, 8'h01);
      if (i == 254) expect_at("sat_cnt_254", cyc, SelErr, 8'hFE);
      if (i == 255) expect_at("sat_cnt_255", cyc, SelErr, 8'hFF);
    end
    n_checks++;
    if (bus.ERR_CNT === 8'hFF) n_pass++;
    else $display("FAIL direct_sat_err: got 0x%0h, expected 0xff", bus.ERR_CNT);
    drive(4'h0, 4'h0, 4'h0);
    expect_all("sat_300", 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    step();
    expect_all("sat_hold", 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);

    // Mid-operation reset clears state asynchronously; V keeps voting.
    drive(4'h3, 4'h3, 4'h0);
    step();
    RST = 1'b1;
    expect_at("arst_v", cyc, SelV, 8'h03);
    expect_all("arst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    expect_all("arst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    RST = 1'b0;
    drive(4'h6, 4'h6, 4'h6);
    step();
    expect_at("final_v", cyc, SelV, 8'h06);
    expect_all("final", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) step();
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      $display("FAIL %s: never compared, expected 0x%0h", e.name, e.val);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
